stack_ctrl: RTL

//  Stack-pointer controller for the CPU's hardware stack (16-bit x NWORDS single-port RAM).

---
 rtl/stack_pkg.sv | 32 +++
 rtl/stack_ptr_cnt.sv | 43 ++++
 rtl/stack_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared types for the hardware stack controller: FSM states, push/pop operation
// encoding and the default stack geometry.
package stack_pkg;

  localparam int STACK_WIDTH_DEFAULT = 16;
  localparam int STACK_DEPTH_DEFAULT = 1024;

  typedef enum logic {
    ST_RUN,
    ST_FAULT
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPL
  } op_t;

  // Push and pop together mean "replace the top of stack".
  function automatic op_t decode_op(input logic push, input logic pop);
    op_t op;
    case ({push, pop})
      2'b10:   op = OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = OP_REPL;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/stack_ptr_cnt.sv
// Up/down stack pointer and fill-level counter; sp is the next free slot and
// wraps modulo NWORDS, top is the slot holding the current top of stack.
module stack_ptr_cnt
  import stack_pkg::*;
#(
  parameter int  NWORDS = STACK_DEPTH_DEFAULT,
  localparam int AW     = $clog2(NWORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [AW-1:0] sp,
  output logic [AW-1:0] top,
  output logic [AW:0]   level
);

  localparam logic [AW-1:0] SP_LAST = AW'(NWORDS - 1);
  localparam logic [AW-1:0] SP_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE = (AW + 1)'(1);

  logic [AW-1:0] sp_inc;
  logic [AW-1:0] sp_dec;

  // Explicit wrap so non-power-of-two depths still index the RAM correctly.
  assign sp_inc = (sp == SP_LAST) ? '0 : sp + SP_ONE;
  assign sp_dec = (sp == '0) ? SP_LAST : sp - SP_ONE;
  assign top    = sp_dec;

  always_ff @(posedge clk) begin
    if (reset) begin
      sp    <= '0;
      level <= '0;
    end else if (inc && !dec) begin
      sp    <= sp_inc;
      level <= level + LVL_ONE;
    end else if (dec && !inc) begin
      sp    <= sp_dec;
      level <= level - LVL_ONE;
    end
  end

endmodule

// File: rtl/stack_ctrl.sv
// Stack-pointer controller for the CPU hardware stack RAM (write on clk, async read).
// Optional STACK_WATERMARK_EN adds the hiwater output (max level since reset).
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int  WIDTH  = STACK_WIDTH_DEFAULT,
  parameter int  NWORDS = STACK_DEPTH_DEFAULT,
  localparam int AW     = $clog2(NWORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  input  logic             clr_fault,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf,
`ifdef STACK_WATERMARK_EN
  output logic [AW:0]      hiwater,
`endif
  output logic             mem_we,
  output logic [AW-1:0]    mem_a,
  output logic [WIDTH-1:0] mem_din,
  input  logic [WIDTH-1:0] mem_dout
);

  localparam logic [AW:0] LVL_FULL = (AW + 1)'(NWORDS);

  op_t           op;
  state_t        state;
  logic          run;
  logic          do_push;
  logic          do_pop;
  logic          do_repl;
  logic          bad_push;
  logic          bad_pop;
  logic [AW-1:0] sp;
  logic [AW-1:0] top;

  assign op    = decode_op(push, pop);
  assign run   = (state == ST_RUN);
  assign full  = (level == LVL_FULL);
  assign empty = (level == '0);

  // Replace is legal at full; any pop-type request on an empty stack underflows.
  assign do_push  = run && (op == OP_PUSH) && !full;
  assign do_pop   = run && (op == OP_POP) && !empty;
  assign do_repl  = run && (op == OP_REPL) && !empty;
  assign bad_push = run && (op == OP_PUSH) && full;
  assign bad_pop  = run && ((op == OP_POP) || (op == OP_REPL)) && empty;

  assign mem_we  = !reset && (do_push || do_repl);
  assign mem_a   = do_push ? sp : top;
  assign mem_din = push_data;

  stack_ptr_cnt #(
    .NWORDS(NWORDS)
  ) u_ptr (
    .clk  (clk),
    .reset(reset),
    .inc  (do_push),
    .dec  (do_pop),
    .sp   (sp),
    .top  (top),
    .level(level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      pop_valid <= 1'b0;
      case (state)
        ST_RUN: begin
          if (clr_fault) begin
            ovf <= 1'b0;
            unf <= 1'b0;
          end
          if (do_pop || do_repl) begin
            pop_data  <= mem_dout;
            pop_valid <= 1'b1;
          end
          if (bad_push) begin
            ovf   <= 1'b1;
            state <= ST_FAULT;
          end
          if (bad_pop) begin
            unf   <= 1'b1;
            state <= ST_FAULT;
          end
        end
        ST_FAULT: begin
          if (clr_fault) begin
            ovf   <= 1'b0;
            unf   <= 1'b0;
            state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef STACK_WATERMARK_EN
  localparam logic [AW:0] LVL_ONE = (AW + 1)'(1);

  // Level only grows through a push, so the peak can only move on do_push.
  always_ff @(posedge clk) begin
    if (reset) begin
      hiwater <= '0;
    end else if (do_push && ((level + LVL_ONE) > hiwater)) begin
      hiwater <= level + LVL_ONE;
    end
  end
`endif

endmodule
